dmem_bridge: RTL
================

# dmem_bridge

Bridge between the single-cycle CPU's memory stage and a slow, handshaked data memory. It consumes the ALU address, rt store data and MemRead/MemWrite that the CPU produces. It stalls the CPU (freezing PC and register write) while a req/ack transaction completes, then presents load data for write-back. It also flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 16: maximum cycles spent in REQ waiting for mem_ack_i (≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_read_i  in  1  CPU load request (MemRead)
- mem_write_i  in  1  CPU store request (MemWrite)
- addr_i  in  32  byte address from ALU result
- wdata_i  in  32  store data (rt)
- rdata_o  out  32  load data to MemtoReg mux; registered
- stall_o  out  1  high: CPU must hold PC and suppress RegWrite this cycle
- err_o  out  1  sticky error flag (misalign or timeout)
- mem_req_o  out  1  memory request, level
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  latched word address
- mem_wdata_o  out  32  latched store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_read_i|mem_write_i: stall_o=1 (combinational, same cycle).
  - Latch addr_i, wdata_i, and we = mem_write_i. Write wins if both are high; no error in that case.
  - If addr_i[1:0]==0: go to REQ, clear wait counter.
  - Else (misaligned): no memory request; rdata reg ← 0; err ← 1; go to DONE.
  - No access: stay in IDLE, stall_o=0.
- REQ:
  - mem_req_o=1, stall_o=1; mem_addr_o, mem_we_o, mem_wdata_o held stable.
  - mem_ack_i=1: if read, rdata reg ← mem_rdata_i; if write, rdata reg unchanged. Go to DONE.
  - No ack and counter==TIMEOUT-1: rdata reg ← 0 (read only); err ← 1; go to DONE.
  - Otherwise: counter+1.
  - An ack on the last allowed cycle counts as success; no error is set.
- DONE:
  - stall_o=0 for exactly one cycle. The CPU completes the instruction on this edge (load writes back rdata_o, PC advances).
  - mem_read_i/mem_write_i, still high for the same instruction, are ignored.
  - Unconditional return to IDLE.
- mem_ack_i outside REQ is ignored.
- err_o stays set until reset and does not block further accesses.
- Counter width: $clog2(TIMEOUT); it never wraps.

## Timing
- Reset (rst_i=0, async): state=IDLE. rdata_o=0, err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counter=0. stall_o follows IDLE logic.
- Reset asserted mid-REQ drops mem_req_o immediately, without waiting for a clock edge.
- An aligned access with ack on the first REQ cycle:
  - cycle 0: IDLE, stall=1
  - cycle 1: REQ, req=1, ack
  - cycle 2: DONE, stall=0
  - Two stall cycles; the instruction occupies 3 cycles.
- Ack on the k-th REQ cycle (k=1..TIMEOUT) gives k+1 stall cycles.
- Timeout gives TIMEOUT+1 stall cycles.
- Misalign gives 1 stall cycle (IDLE→DONE).
- rdata_o is stable from the DONE cycle until the next completed read or reset.
- Back-to-back memory instructions: DONE→IDLE, and the next access starts in the following IDLE cycle. There is one non-stall cycle between transactions (DONE) and no idle gap beyond it.
- Non-memory instructions in IDLE: zero added latency.

## Test plan
- Reset: hold rst_i=0 with mem_read_i=1 and a clock running. Require all registered outputs 0 and mem_req_o=0. Release reset: next cycle stall_o=1, then REQ.
- Aligned load: addr_i=0x0000_0010, ack after 3 REQ cycles with mem_rdata_i=0x1234_5678.
  - mem_addr_o=0x10, mem_we_o=0.
  - stall_o high for 4 cycles.
  - DONE cycle: rdata_o=0x1234_5678, stall_o=0, err_o=0.
- Aligned store: addr_i=0x20, wdata_i=0xCAFE_F00D, ack on the first REQ cycle.
  - mem_we_o=1, mem_wdata_o=0xCAFE_F00D.
  - 2 stall cycles; rdata_o unchanged from the prior load.
  - With both mem_read_i and mem_write_i=1, still a write.
- Misaligned: load at addr_i=0x0000_0006. Require:
  - mem_req_o never asserts.
  - Exactly 1 stall cycle.
  - DONE: rdata_o=0, err_o=1, and err_o remains 1 across subsequent good accesses.
- Timeout: TIMEOUT=16, read, ack never arrives.
  - mem_req_o high for exactly 16 cycles, then 0.
  - DONE: rdata_o=0, err_o=1.
  - Repeat with ack on REQ cycle 16: no error, data captured.
- Reset mid-REQ plus spurious ack:
  - Pulse rst_i low during REQ cycle 2: mem_req_o falls asynchronously and the FSM restarts from IDLE.
  - An ack pulse in IDLE or DONE must not alter rdata_o or state.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: stalls the single-cycle CPU's memory stage across a req/ack
// transaction with a slow data memory, returns registered load data, and
// raises a sticky error on misaligned accesses or memory timeouts.
module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Wait counter counts REQ cycles already spent without an ack.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_access;
  logic          w_aligned;
  logic          w_last;
  logic          w_start;

  assign w_access  = mem_read_i | mem_write_i;
  assign w_aligned = (addr_i[1:0] == 2'b00);
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_start   = (r_state == S_IDLE) && w_access;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: misaligned accesses skip the memory entirely.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next = w_aligned ? S_REQ : S_DONE;
      S_REQ:   if (mem_ack_i || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the IDLE stall depends on the live request so
  // the CPU is held in the same cycle the memory instruction appears.
  always_comb begin
    mem_req_o = 1'b0;
    stall_o   = 1'b0;
    case (r_state)
      S_IDLE:  stall_o = w_access;
      S_REQ:   begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
      end
      default: begin
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
      end
    endcase
  end

  // Capture the access at the start of an instruction; held through REQ.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_we    <= mem_write_i;
    end
  end

  // Wait counter: cleared on entry to REQ, advances while no ack, stops at
  // the last allowed cycle so it never wraps.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (w_start && w_aligned) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) && !mem_ack_i && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Load data and sticky error; acks outside REQ never reach this logic.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_start && !w_aligned) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end else if (r_state == S_REQ) begin
      if (mem_ack_i) begin
        if (!r_we) r_rdata <= mem_rdata_i;
      end else if (w_last) begin
        if (!r_we) r_rdata <= '0;
        r_err <= 1'b1;
      end
    end
  end

  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule
